// File: rtl/arith_unit_reg.sv
// Registered ripple-carry arithmetic unit: ADD, SUB, INC, DEC on operand A.
// The result and carry-out are registered, giving one cycle of latency.
module arith_unit_reg #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [1:0]       CONTROL,
   output logic [WIDTH-1:0] R,
   output logic             C
);

   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_SUB = 2'b01,
      OP_INC = 2'b10,
      OP_DEC = 2'b11
   } op_e;

   logic [WIDTH-1:0] y_c;
   logic             cin_c;
   logic [WIDTH:0]   carry_c;
   logic [WIDTH-1:0] sum_c;

   logic [WIDTH-1:0] r_d, r_q;
   logic             c_d, c_q;

   // Adder B-side operand selection/inversion and carry-in mux
   always_comb begin
      y_c   = B;
      cin_c = 1'b0;
      unique case (op_e'(CONTROL))
         OP_ADD: begin
            y_c   = B;
            cin_c = 1'b0;
         end
         OP_SUB: begin
            y_c   = ~B;
            cin_c = 1'b1;
         end
         OP_INC: begin
            y_c   = '0;
            cin_c = 1'b1;
         end
         OP_DEC: begin
            y_c   = '1;
            cin_c = 1'b0;
         end
         default: begin
            y_c   = B;
            cin_c = 1'b0;
         end
      endcase
   end

   // Ripple-carry chain of full adders, carry-out lands in carry_c[WIDTH]
   always_comb begin
      carry_c    = '0;
      sum_c      = '0;
      carry_c[0] = cin_c;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         sum_c[i]     = A[i] ^ y_c[i] ^ carry_c[i];
         carry_c[i+1] = (A[i] & y_c[i]) | (carry_c[i] & (A[i] ^ y_c[i]));
      end
   end

   // Next-state values for the output register
   always_comb begin
      r_d = sum_c;
      c_d = carry_c[WIDTH];
   end

   // Output register; reset takes priority and discards the sampled operation
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_q <= '0;
         c_q <= 1'b0;
      end else begin
         r_q <= r_d;
         c_q <= c_d;
      end
   end

   assign R = r_q;
   assign C = c_q;

endmodule

// File: tb/tb_arith_unit_reg.sv
// Self-checking bench for arith_unit_reg: directed steps plus random ops,
// expected {C,R} pushed to a scoreboard queue at drive time, popped after the edge.
module tb_arith_unit_reg;

   localparam int unsigned W = 8;

   logic         CLK;
   logic         RST;
   logic [W-1:0] A;
   logic [W-1:0] B;
   logic [1:0]   CONTROL;
   logic [W-1:0] R;
   logic         C;

   int tests_run;
   int tests_failed;

   logic [W:0] sb_q[$];
   logic [W:0] last_exp;
   bit         have_last;
   logic [W:0] inc_aa_obs;

   arith_unit_reg #(.WIDTH(W)) dut (
      .CLK     (CLK),
      .RST     (RST),
      .A       (A),
      .B       (B),
      .CONTROL (CONTROL),
      .R       (R),
      .C       (C)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Reference behaviour written from the operation definitions, returns {C,R}
   function automatic logic [W:0] model(input logic [1:0] ctl, input logic [W-1:0] a,
                                        input logic [W-1:0] b);
      logic [W:0] res;
      case (ctl)
         2'b00:   res = {1'b0, a} + {1'b0, b};
         2'b01:   res = {(a >= b), W'(a - b)};
         2'b10:   res = {(a == {W{1'b1}}), W'(a + W'(1))};
         default: res = {(a != '0), W'(a - W'(1))};
      endcase
      return res;
   endfunction

   task automatic check_out(input string tag);
      logic [W:0] exp;
      logic [W:0] obs;
      obs = {C, R};
      tests_run++;
      if (sb_q.size() == 0) begin
         tests_failed++;
         $error("FAIL %s: scoreboard empty, observed %h", tag, obs);
      end else begin
         exp = sb_q.pop_front();
         last_exp  = exp;
         have_last = 1'b1;
         assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: {C,R} observed %h expected %h", tag, obs, exp);
         end
      end
   endtask

   // Drive one operation at negedge, confirm outputs hold, then check after the edge
   task automatic step(input logic rst, input logic [1:0] ctl, input logic [W-1:0] a,
                       input logic [W-1:0] b, input string tag);
      @(negedge CLK);
      RST     = rst;
      CONTROL = ctl;
      A       = a;
      B       = b;
      sb_q.push_back(rst ? '0 : model(ctl, a, b));
      if (have_last) begin
         #1;
         tests_run++;
         assert ({C, R} === last_exp) else begin
            tests_failed++;
            $error("FAIL %s_hold: {C,R} observed %h expected %h", tag, {C, R}, last_exp);
         end
      end
      @(posedge CLK);
      #1;
      check_out(tag);
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      have_last    = 1'b0;
      RST     = 1'b1;
      A       = 8'hFF;
      B       = 8'hFF;
      CONTROL = 2'b00;

      // Reset held for two cycles, then released with the same inputs
      step(1'b1, 2'b00, 8'hFF, 8'hFF, "reset0");
      step(1'b1, 2'b00, 8'hFF, 8'hFF, "reset1");
      step(1'b0, 2'b00, 8'hFF, 8'hFF, "post_reset_add");

      // Basic sequence
      step(1'b0, 2'b00, 8'h02, 8'h01, "add_basic");
      step(1'b0, 2'b01, 8'h08, 8'h01, "sub_basic");
      step(1'b0, 2'b10, 8'h04, 8'h00, "inc_basic");
      step(1'b0, 2'b11, 8'h01, 8'h00, "dec_basic");
      step(1'b0, 2'b00, 8'h00, 8'h00, "add_zero");

      // Wrap boundaries
      step(1'b0, 2'b10, 8'hFF, 8'h00, "inc_wrap");
      step(1'b0, 2'b11, 8'h00, 8'h00, "dec_wrap");
      step(1'b0, 2'b00, 8'h80, 8'h80, "add_wrap");

      // Borrow
      step(1'b0, 2'b01, 8'h01, 8'h02, "sub_borrow");
      step(1'b0, 2'b01, 8'h55, 8'h55, "sub_equal");

      // B ignored for INC/DEC
      step(1'b0, 2'b10, 8'h37, 8'hAA, "inc_b_aa");
      inc_aa_obs = {C, R};
      step(1'b0, 2'b10, 8'h37, 8'h00, "inc_b_00");
      tests_run++;
      assert ({C, R} === inc_aa_obs) else begin
         tests_failed++;
         $error("FAIL inc_b_ignored: {C,R} observed %h expected %h", {C, R}, inc_aa_obs);
      end
      step(1'b0, 2'b11, 8'hC4, 8'hAA, "dec_b_aa");
      step(1'b0, 2'b11, 8'hC4, 8'h00, "dec_b_00");

      // Mid-stream reset
      step(1'b0, 2'b00, 8'h7F, 8'h01, "mid_pre");
      step(1'b1, 2'b01, 8'h90, 8'h10, "mid_reset");
      step(1'b0, 2'b01, 8'h90, 8'h10, "mid_resume");
      step(1'b0, 2'b11, 8'h10, 8'h33, "mid_after");

      // Random operations
      for (int i = 0; i < 60; i++) begin
         step(1'b0, 2'($urandom_range(3)), 8'($urandom), 8'($urandom), "random");
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
